sender_pam_framer: RTL and testbench



---
 rtl/sender_pam_framer.sv | 150 +++++++++++++++
 tb/tb_sender_pam_framer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sender_pam_framer.sv
// Framed PAM transmitter: captures a packed multi-channel ADC word at frame start and
// serialises preamble, channel payloads and even parity as PAM symbols on the DAC bus.
module sender_pam_framer #(
  parameter int               DATA_W   = 8,
  parameter int               CHANNELS = 2,
  parameter int               PRE_W    = 8,
  parameter logic [PRE_W-1:0] PREAMBLE = 8'hA5,
  parameter int               SYM_BITS = 1,
  parameter int               SYM_CYC  = 4,
  parameter int               GAP_SYM  = 2
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       sender_sync_in,
  input  logic [CHANNELS*DATA_W-1:0] sender_ad,
  output logic [DATA_W-1:0]          sender_da,
  output logic                       sender_sync_out,
  output logic                       sender_busy,
  output logic [15:0]                sender_frame_cnt
);

  localparam int PAY_W   = CHANNELS * DATA_W;
  localparam int PAY_END = PRE_W + PAY_W;
  localparam int FB      = PAY_END + 1;
  localparam int NSYM    = (FB + SYM_BITS - 1) / SYM_BITS;
  localparam int FBP     = NSYM * SYM_BITS;
  localparam int GAP_CYC = GAP_SYM * SYM_CYC;
  localparam int SW      = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int CW      = (SYM_CYC > 1) ? $clog2(SYM_CYC) : 1;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [SW-1:0]     LAST_SYM = SW'(NSYM - 1);
  localparam logic [CW-1:0]     LAST_CYC = CW'(SYM_CYC - 1);
  localparam logic [GW-1:0]     LAST_GAP = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [DATA_W+SYM_BITS-1:0] FULL_X = {{SYM_BITS{1'b0}}, {DATA_W{1'b1}}};
  localparam logic [DATA_W+SYM_BITS-1:0] MAXV_X = {{DATA_W{1'b0}}, {SYM_BITS{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_PAY, S_PAR, S_GAP} state_t;

  state_t          state;
  logic [FBP-1:0]  frame_sr;
  logic [SW-1:0]   sym_idx;
  logic [CW-1:0]   cyc_cnt;
  logic [GW-1:0]   gap_cnt;

  logic            in_frame;
  logic            sym_end;
  logic            frame_end;
  logic            gap_end;
  logic            decide;
  logic [FBP-1:0]  fresh;

  // Frame image, first-transmitted bit at the MSB; pad bits stay zero below parity.
  function automatic logic [FBP-1:0] build_frame(input logic [PAY_W-1:0] ad);
    logic [FBP-1:0] f;
    f = '0;
    f[FBP-1 -: PRE_W] = PREAMBLE;
    for (int c = 0; c < CHANNELS; c++) begin
      f[FBP-1-PRE_W-c*DATA_W -: DATA_W] = ad[c*DATA_W +: DATA_W];
    end
    f[FBP-FB] = ^ad;
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] level_of(input logic [SYM_BITS-1:0] v);
    logic [DATA_W+SYM_BITS-1:0] prod;
    prod = ({{DATA_W{1'b0}}, v} * FULL_X) / MAXV_X;
    return prod[DATA_W-1:0];
  endfunction

  function automatic state_t phase_of(input logic [SW-1:0] idx);
    int b;
    b = int'(idx) * SYM_BITS;
    if (b < PRE_W) begin
      return S_PRE;
    end else if (b < PAY_END) begin
      return S_PAY;
    end else begin
      return S_PAR;
    end
  endfunction

  // Decision point is IDLE, the last gap cycle, or the last frame cycle when there is no gap.
  always_comb begin
    in_frame  = (state == S_PRE) || (state == S_PAY) || (state == S_PAR);
    sym_end   = in_frame && (cyc_cnt == LAST_CYC);
    frame_end = sym_end && (sym_idx == LAST_SYM);
    gap_end   = (state == S_GAP) && (gap_cnt == LAST_GAP);
    decide    = (state == S_IDLE) || gap_end || ((GAP_SYM == 0) && frame_end);
    fresh     = build_frame(sender_ad);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state            <= S_IDLE;
      frame_sr         <= '0;
      sym_idx          <= '0;
      cyc_cnt          <= '0;
      gap_cnt          <= '0;
      sender_da        <= MID;
      sender_sync_out  <= 1'b0;
      sender_busy      <= 1'b0;
      sender_frame_cnt <= 16'd0;
    end else begin
      if (frame_end) begin
        sender_frame_cnt <= sender_frame_cnt + 16'd1;
      end
      if (decide) begin
        sym_idx <= '0;
        cyc_cnt <= '0;
        gap_cnt <= '0;
        if (sender_sync_in) begin
          // frame_sr holds the not-yet-sent remainder of the captured frame
          state           <= S_PRE;
          frame_sr        <= fresh << SYM_BITS;
          sender_da       <= level_of(fresh[FBP-1 -: SYM_BITS]);
          sender_sync_out <= 1'b1;
          sender_busy     <= 1'b1;
        end else begin
          state           <= S_IDLE;
          sender_da       <= MID;
          sender_sync_out <= 1'b0;
          sender_busy     <= 1'b0;
        end
      end else if (frame_end) begin
        state           <= S_GAP;
        cyc_cnt         <= '0;
        gap_cnt         <= '0;
        sender_da       <= MID;
        sender_sync_out <= 1'b0;
      end else if (sym_end) begin
        state           <= phase_of(sym_idx + SW'(1));
        sym_idx         <= sym_idx + SW'(1);
        cyc_cnt         <= '0;
        frame_sr        <= frame_sr << SYM_BITS;
        sender_da       <= level_of(frame_sr[FBP-1 -: SYM_BITS]);
        sender_sync_out <= 1'b0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else if (in_frame) begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end else begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sender_pam_framer.sv
// Scoreboard bench for sender_pam_framer: a default 2-level instance and a 4-level instance.
module tb_sender_pam_framer;

  typedef struct packed {
    logic [7:0]  da;
    logic        sync;
    logic        busy;
    logic [15:0] cnt;
  } obs_t;

  logic        clock = 1'b0;
  logic        resetN;
  logic        sync_in;
  logic        sync_in2;
  logic [15:0] ad;

  logic [7:0]  da1, da2;
  logic        so1, so2, busy1, busy2;
  logic [15:0] cnt1, cnt2;

  obs_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  sender_pam_framer dut (
    .clock(clock), .resetN(resetN), .sender_sync_in(sync_in), .sender_ad(ad),
    .sender_da(da1), .sender_sync_out(so1), .sender_busy(busy1), .sender_frame_cnt(cnt1)
  );

  sender_pam_framer #(.SYM_BITS(2)) dut2 (
    .clock(clock), .resetN(resetN), .sender_sync_in(sync_in2), .sender_ad(ad),
    .sender_da(da2), .sender_sync_out(so2), .sender_busy(busy2), .sender_frame_cnt(cnt2)
  );

  task automatic push_idle(input int n, input logic [15:0] c);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e.da = 8'h80; e.sync = 1'b0; e.busy = 1'b0; e.cnt = c;
      q.push_back(e);
    end
  endtask

  // Expected per-cycle outputs of one frame plus its 8-cycle gap.
  task automatic push_frame(input int sb, input logic [15:0] adv, input logic [15:0] c0);
    bit         bq[$];
    logic [7:0] pre;
    logic [7:0] lvl;
    logic [1:0] v;
    obs_t       e;
    pre = 8'hA5;
    for (int i = 7; i >= 0; i--) bq.push_back(pre[i]);
    for (int ch = 0; ch < 2; ch++)
      for (int i = 7; i >= 0; i--) bq.push_back(adv[ch*8+i]);
    bq.push_back(^adv);
    while ((bq.size() % sb) != 0) bq.push_back(1'b0);
    for (int s = 0; s < bq.size() / sb; s++) begin
      if (sb == 1) begin
        lvl = bq[s] ? 8'hFF : 8'h00;
      end else begin
        v = {bq[2*s], bq[2*s+1]};
        case (v)
          2'd0:    lvl = 8'h00;
          2'd1:    lvl = 8'h55;
          2'd2:    lvl = 8'hAA;
          default: lvl = 8'hFF;
        endcase
      end
      for (int c = 0; c < 4; c++) begin
        e.da = lvl; e.sync = (s == 0); e.busy = 1'b1; e.cnt = c0;
        q.push_back(e);
      end
    end
    for (int g = 0; g < 8; g++) begin
      e.da = 8'h80; e.sync = 1'b0; e.busy = 1'b1; e.cnt = c0 + 16'd1;
      q.push_back(e);
    end
  endtask

  task automatic step(input int which, input string tag);
    obs_t o, e;
    @(negedge clock);
    if (which == 0) o = {da1, so1, busy1, cnt1};
    else            o = {da2, so2, busy2, cnt2};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed da=%h sync=%b busy=%b cnt=%h, expected da=%h sync=%b busy=%b cnt=%h",
               tag, o.da, o.sync, o.busy, o.cnt, e.da, e.sync, e.busy, e.cnt);
      end
    end
  endtask

  task automatic drain(input int which, input string tag);
    while (q.size() > 0) step(which, tag);
  endtask

  initial begin
    resetN = 1'b0; sync_in = 1'b1; sync_in2 = 1'b1; ad = 16'h0000;

    // reset held with sync_in high
    push_idle(3, 16'd0);
    drain(0, "reset");
    resetN = 1'b1; sync_in = 1'b0; sync_in2 = 1'b0;
    push_idle(2, 16'd0);
    drain(0, "idle");

    // single frame, 2-level
    ad = 16'h2120; sync_in = 1'b1;
    push_frame(1, ad, 16'd0);
    step(0, "single");
    sync_in = 1'b0;
    drain(0, "single");
    push_idle(3, 16'd1);
    drain(0, "single_idle");

    // continuous frames, sample change mid-frame only affects the next frame
    ad = 16'h5A3C; sync_in = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_frame(1, ad, 16'(f + 1));
      for (int c = 1; c <= 108; c++) begin
        step(0, "cont");
        if (f == 1 && c == 50) ad = 16'hC381;
        if (f == 2 && c == 108) sync_in = 1'b0;
      end
    end
    push_idle(2, 16'd4);
    drain(0, "cont_idle");

    // 4-level PAM
    ad = 16'h2120; sync_in2 = 1'b1;
    push_frame(2, ad, 16'd0);
    step(1, "pam4");
    sync_in2 = 1'b0;
    drain(1, "pam4");
    push_idle(2, 16'd1);
    drain(1, "pam4_idle");

    // sync_in dropped mid-frame
    ad = 16'h00FF; sync_in = 1'b1;
    push_frame(1, ad, 16'd4);
    for (int c = 1; c <= 108; c++) begin
      step(0, "drop");
      if (c == 30) sync_in = 1'b0;
    end
    push_idle(2, 16'd5);
    drain(0, "drop_idle");

    // reset mid-frame
    ad = 16'h7E01; sync_in = 1'b1;
    push_frame(1, ad, 16'd5);
    for (int c = 1; c <= 50; c++) begin
      step(0, "abort");
      if (c == 1) sync_in = 1'b0;
    end
    resetN = 1'b0;
    q.delete();
    push_idle(1, 16'd0);
    step(0, "abort_rst");
    resetN = 1'b1;
    push_idle(2, 16'd0);
    drain(0, "abort_idle");

    // counter wrap
    force dut.sender_frame_cnt = 16'hFFFF;
    #1;
    release dut.sender_frame_cnt;
    push_idle(1, 16'hFFFF);
    step(0, "preload");
    ad = 16'h1234; sync_in = 1'b1;
    push_frame(1, ad, 16'hFFFF);
    step(0, "wrap");
    sync_in = 1'b0;
    drain(0, "wrap");
    push_idle(2, 16'h0000);
    drain(0, "wrap_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
